imm_decode_pipe: RTL and testbench
==================================

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 Parameter XLEN, default 64: datapath width; legal values 32 and 64 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous pipeline kill; discards all held entries.
REQ-005 in_valid  input  1  instruction word presented.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 inst  input  32  RISC-V instruction word.
REQ-008 out_valid  output  1  decoded result presented.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 imm  output  XLEN  fully formed, sign-extended immediate.
REQ-011 fmt  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-012 inst_q  output  32  instruction word paired with imm/fmt.

Function
REQ-013 Decode by opcode inst[6:0]:
- I-type: 0000011, 0010011, 0011011, 1100111.
- S-type: 0100011.
- B-type: 1100011.
- U-type: 0110111, 0010111.
- J-type: 1101111.
- Any other opcode: fmt 0, imm 0.
REQ-014 Immediate formation:
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- U: {inst[31:12], 12'h000}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
REQ-015 All formats SHALL sign-extend from their top bit (imm[11], [12], [31] or [20]) to XLEN; S-type is sign-extended.
REQ-016 For XLEN=32, U-type SHALL be the raw 32-bit value with no extension.
REQ-017 Accept handshake: a word is accepted when in_valid && in_ready.
REQ-018 Result handshake: a result is consumed when out_valid && out_ready.
REQ-019 Latency SHALL be 1 cycle: a word accepted in cycle N appears on out_valid/imm/fmt/inst_q in cycle N+1.
REQ-020 Storage SHALL be a 2-entry skid buffer (output register plus skid register); results leave in strict acceptance order.
REQ-021 in_ready SHALL be driven directly from a register and equal "skid register empty".
REQ-022 Accept while the output register is full and not consumed: the result SHALL go to the skid register, and in_ready SHALL deassert next cycle.
REQ-023 Consume while the skid register is full: skid contents SHALL move to the output register, and in_ready SHALL reassert next cycle.
REQ-024 Simultaneous accept and consume with the skid register empty: the output register SHALL load the new result, with no bubble.
REQ-025 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-026 flush SHALL clear both entries next cycle (out_valid 0, in_ready 1); any word offered in the flush cycle SHALL be dropped; flush has priority over all handshakes.

Reset
REQ-027 While rstn is low: out_valid 0, imm 0, fmt 0, inst_q 0, skid empty, in_ready 1.
REQ-028 Reset asserted mid-transfer SHALL discard both entries immediately, with no partial output.
REQ-029 The first accept is permitted in the first rising edge after rstn is released.

Configuration
REQ-030 Macro IMM_CSR_ZIMM_EN.
- Defined: opcode 1110011 with inst[14]=1 SHALL give fmt 6 and imm = zero-extended inst[19:15].
- Undefined: opcode 1110011 SHALL give fmt 0 and imm 0.

Verification
REQ-031 XLEN=64, inst 0xFFF00093 (addi x1,x0,-1) -> next cycle imm 0xFFFFFFFFFFFFFFFF, fmt 1.
REQ-032 XLEN=64, inst 0xFE20AE23 (sw x2,-4(x1)) -> imm 0xFFFFFFFFFFFFFFFC, fmt 2; inst 0xFE000CE3 (beq -8) -> imm 0xFFFFFFFFFFFFFFF8, fmt 3.
REQ-033 XLEN=32, inst 0x123450B7 (lui) -> imm 0x12345000, fmt 4.
REQ-034 Backpressure: out_ready held 0 while 3 words are offered back to back -> first 2 accepted, in_ready 0 for the third; releasing out_ready yields results in original order with no loss or duplication.
REQ-035 Assert flush with 2 entries held and in_valid=1 -> next cycle out_valid 0, in_ready 1, flushed word never appears at the output.
REQ-036 inst 0x300FD073 (csrrwi) -> imm 31, fmt 6 with IMM_CSR_ZIMM_EN defined; imm 0, fmt 0 without it.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RISC-V immediate decoder behind a 2-entry skid buffer.
// One-cycle latency, strict in-order delivery, in_ready straight from a flop.
// Optional feature: define IMM_CSR_ZIMM_EN to decode CSR-immediate (zimm)
// for opcode 1110011 with inst[14]=1 as fmt 6. When the macro is undefined,
// that opcode decodes as fmt 0 with imm 0.
module imm_decode_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [31:0]     inst_q
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_CSR_ZIMM_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef struct packed {
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [31:0]     inst;
  } entry_t;

  // Immediates are built at 64 bits and truncated; for XLEN=32 this leaves
  // the U-type value raw and every other format sign-extended to 32 bits.
  function automatic entry_t decode(input logic [31:0] w);
    entry_t      e;
    logic [63:0] x;
    logic [2:0]  f;
    x = '0;
    f = FMT_NONE;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        f = FMT_I;
        x = {{52{w[31]}}, w[31:20]};
      end
      7'b0100011: begin
        f = FMT_S;
        x = {{52{w[31]}}, w[31:25], w[11:7]};
      end
      7'b1100011: begin
        f = FMT_B;
        x = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        f = FMT_U;
        x = {{32{w[31]}}, w[31:12], 12'h000};
      end
      7'b1101111: begin
        f = FMT_J;
        x = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
`ifdef IMM_CSR_ZIMM_EN
      7'b1110011: begin
        if (w[14]) begin
          f = FMT_Z;
          x = {59'd0, w[19:15]};
        end
      end
`endif
      default: begin
        f = FMT_NONE;
        x = '0;
      end
    endcase
    e.fmt  = f;
    e.imm  = x[XLEN-1:0];
    e.inst = w;
    return e;
  endfunction

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  logic   accept;
  logic   consume;
  entry_t dec;

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;
  assign dec     = decode(inst);

  // Next-state of the output/skid pair; flush overrides every handshake.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      // Output slot frees up: refill from skid first to keep order.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new result in the skid slot.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers; reset empties both slots and zeroes the visible outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = out_q.imm;
  assign fmt       = out_q.fmt;
  assign inst_q    = out_q.inst;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Scoreboard bench for imm_decode_pipe: XLEN=64 and XLEN=32 instances share
// stimulus; expected results are queued on accept and checked at the head.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic [31:0] inst_q;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [31:0] inst_q32;

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [63:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .inst(inst), .out_valid(out_valid),
    .out_ready(out_ready), .imm(imm), .fmt(fmt), .inst_q(inst_q)
  );

  imm_decode_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .inst(inst), .out_valid(out_valid32),
    .out_ready(out_ready), .imm(imm32), .fmt(fmt32), .inst_q(inst_q32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode, 64-bit result; the XLEN=32 result is its low half.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e.inst = w;
    e.fmt  = 3'd0;
    e.imm  = 64'd0;
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        e.fmt = 3'd1; e.imm = 64'($signed(w[31:20]));
      end
      7'h23: begin
        e.fmt = 3'd2; e.imm = 64'($signed({w[31:25], w[11:7]}));
      end
      7'h63: begin
        e.fmt = 3'd3; e.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4; e.imm = 64'($signed({w[31:12], 12'h000}));
      end
      7'h6F: begin
        e.fmt = 3'd5; e.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      end
`ifdef IMM_CSR_ZIMM_EN
      7'h73: if (w[14]) begin
        e.fmt = 3'd6; e.imm = {59'd0, w[19:15]};
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // One clock: drive at negedge, check held state, predict, advance.
  task automatic cycle(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    exp_t e;
    in_valid = v; inst = w; out_ready = rdy; flush = fl;
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, sb.size() < 2);
    chk("out_valid32", out_valid32, sb.size() != 0);
    chk("in_ready32", in_ready32, sb.size() < 2);
    if (out_valid && sb.size() != 0) begin
      e = sb[0];
      chk("imm64", imm, e.imm);
      chk("fmt64", fmt, e.fmt);
      chk("inst_q", inst_q, e.inst);
      chk("imm32", imm32, e.imm & 64'hFFFF_FFFF);
      chk("fmt32", fmt32, e.fmt);
      if (!fl && rdy) void'(sb.pop_front());
    end
    if (!fl && v && in_ready) sb.push_back(model(w));
    @(posedge clk);
    if (fl) sb.delete();
    @(negedge clk);
  endtask

  logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
  logic [31:0] dir [12] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
                            32'h300FD073, 32'h30009073, 32'h800000EF, 32'h80000017,
                            32'h002081B3, 32'hFFF1B193, 32'hFFC08067, 32'h7FFFF06F};

  initial begin
    exp_t e;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_imm", imm, 64'd0);
    chk("rst_fmt", fmt, 3'd0);
    chk("rst_inst_q", inst_q, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Spot values from the spec vectors, independent of the model.
    e = model(32'hFFF00093); chk("addi_imm", e.imm, 64'hFFFFFFFFFFFFFFFF);
    e = model(32'hFE20AE23); chk("sw_imm", e.imm, 64'hFFFFFFFFFFFFFFFC);
    e = model(32'hFE000CE3); chk("beq_imm", e.imm, 64'hFFFFFFFFFFFFFFF8);
    e = model(32'h123450B7); chk("lui_imm", e.imm, 64'h12345000);

    // Directed stream with consumer always ready (accept+consume, no bubble).
    foreach (dir[i]) cycle(1'b1, dir[i], 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Direct checks of the spec vectors one cycle after accept.
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    chk("addi_fmt", fmt, 3'd1);
    chk("addi_imm_dut", imm, 64'hFFFFFFFFFFFFFFFF);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h123450B7, 1'b0, 1'b0);
    chk("lui32_imm", imm32, 64'h12345000);
    chk("lui32_fmt", fmt32, 3'd4);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h300FD073, 1'b0, 1'b0);
`ifdef IMM_CSR_ZIMM_EN
    chk("csr_fmt", fmt, 3'd6);
    chk("csr_imm", imm, 64'd31);
`else
    chk("csr_fmt", fmt, 3'd0);
    chk("csr_imm", imm, 64'd0);
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: three back-to-back words with the consumer stalled.
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with both slots full and a word offered.
    cycle(1'b1, 32'h00400213, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500293, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 1'b0, 1'b1);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic, occasional flush.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      logic        f;
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 11)];
      f = ($urandom_range(0, 29) == 0);
      cycle($urandom_range(0, 3) != 0, w, f ? 1'b0 : ($urandom_range(0, 2) != 0), f);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with both slots occupied.
    cycle(1'b1, 32'h00700393, 1'b0, 1'b0);
    cycle(1'b1, 32'h00800413, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_imm", imm, 64'd0);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    // First edge after release accepts.
    cycle(1'b1, 32'hFE000CE3, 1'b0, 1'b0);
    chk("post_rst_fmt", fmt, 3'd3);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
